// File: rtl/mem_bus_arbiter.sv
// Single-port memory sequencer: arbitrates instruction fetch against load/store,
// load/store first, with a starvation counter that guarantees fetch progress.
module mem_bus_arbiter #(
  parameter int WAIT_STATES  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [7:0]  if_addr,
  output logic        if_gnt,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [15:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  output logic        mem_en,
  output logic        mem_rw,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] WAIT_INIT  = 4'(WAIT_STATES);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t      state;
  logic [3:0]  starve_cnt;
  logic [3:0]  wait_cnt;
  logic        cap_is_if;
  logic        cap_we;
  logic [15:0] cap_addr;
  logic [31:0] cap_wdata;
  logic        grant_if;
  logic        grant_ls;

  // Load/store wins a contested arbitration unless fetch has lost STARVE_LIMIT times in a row.
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (if_req && ls_req) begin
      grant_if = (starve_cnt == STARVE_MAX);
      grant_ls = !grant_if;
    end else begin
      grant_if = if_req;
      grant_ls = ls_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      wait_cnt   <= 4'd0;
      cap_is_if  <= 1'b0;
      cap_we     <= 1'b0;
      cap_addr   <= 16'd0;
      cap_wdata  <= 32'd0;
      if_gnt     <= 1'b0;
      if_done    <= 1'b0;
      if_rdata   <= 32'd0;
      ls_gnt     <= 1'b0;
      ls_done    <= 1'b0;
      ls_rdata   <= 32'd0;
    end else begin
      if_gnt  <= 1'b0;
      ls_gnt  <= 1'b0;
      if_done <= 1'b0;
      ls_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_if || grant_ls) begin
            state     <= ACCESS;
            wait_cnt  <= WAIT_INIT;
            cap_is_if <= grant_if;
            if_gnt    <= grant_if;
            ls_gnt    <= grant_ls;
            if (grant_if) begin
              cap_addr   <= {8'h00, if_addr};
              cap_we     <= 1'b0;
              cap_wdata  <= 32'd0;
              starve_cnt <= 4'd0;
            end else begin
              cap_addr  <= ls_addr;
              cap_we    <= ls_we;
              cap_wdata <= ls_wdata;
              // Fetch was waiting and lost; the counter never passes the limit
              // because at the limit fetch wins instead.
              if (if_req && (starve_cnt != STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 4'd1;
              end
            end
          end
        end
        ACCESS: begin
          if (wait_cnt == 4'd0) begin
            state   <= DONE;
            if_done <= cap_is_if;
            ls_done <= !cap_is_if;
            if (!cap_we) begin
              if (cap_is_if) begin
                if_rdata <= mem_rdata;
              end else begin
                ls_rdata <= mem_rdata;
              end
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The bus is a pure decode of state and captured registers so reset drops it immediately.
  assign busy      = (state != IDLE);
  assign mem_en    = (state == ACCESS);
  assign mem_rw    = mem_en && cap_we;
  assign mem_addr  = mem_en ? cap_addr : 16'd0;
  assign mem_wdata = mem_rw ? cap_wdata : 32'd0;

endmodule
